// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, FSM state type and row-address helper for the sprite row fetcher
package sprite_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;
    localparam int ROWS   = 16;
    localparam int WPR    = 4;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int WIDX_W = $clog2(WPR);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fsm_state_t;

    // First ROM word of a sprite row, wrapped to the ROM address space
    function automatic logic [ADDR_W-1:0] row_base(input logic [ID_W-1:0] sprite, input logic [ROW_W-1:0] row);
        logic [31:0] v;
        v = (32'(sprite) * ROWS + 32'(row)) * WPR;
        return v[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_word_fifo.sv
// sprite_word_fifo: synchronous FIFO with occupancy count and same-cycle push/pop
module sprite_word_fifo #(
    parameter int W = 33,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_pop,
    output logic [W-1:0]     o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push, w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // Pointers and occupancy; reset empties the buffer without touching storage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher: credit-based ROM read master streaming one sprite row over valid/ready
module sprite_row_fetcher
    import sprite_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ID_W-1:0]   i_req_sprite,
    input  logic [ROW_W-1:0]  i_req_row,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_chipselect,
    input  logic [DATA_W-1:0] i_avm_readdata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least READ_LATENCY+1");
    end

    fsm_state_t              r_state, w_next;
    logic [ADDR_W-1:0]       r_base;
    logic [WIDX_W-1:0]       r_word_idx;
    logic [READ_LATENCY-1:0] r_sr_valid, r_sr_last;
    logic [CNT_W-1:0]        w_fifo_count;
    logic [CR_W-1:0]         w_inflight;
    logic                    w_credit_ok, w_issue, w_fifo_empty, w_pop, w_head_last;
    logic [DATA_W-1:0]       w_head_data;

    assign w_inflight  = CR_W'($countones(r_sr_valid));
    assign w_credit_ok = (CR_W'(w_fifo_count) + w_inflight) < CR_W'(FIFO_DEPTH);
    assign w_issue     = o_avm_chipselect;
    assign o_out_valid = !w_fifo_empty;
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_out_data  = w_fifo_empty ? '0 : w_head_data;
    assign o_out_last  = !w_fifo_empty && w_head_last;
    assign o_busy      = (r_state != IDLE);

    // Next state and ROM issue: reads go out only while buffer plus in-flight leaves room
    always_comb begin
        w_next           = r_state;
        o_req_ready      = 1'b0;
        o_avm_chipselect = 1'b0;
        o_avm_address    = '0;
        unique case (r_state)
            IDLE: begin
                o_req_ready = !i_reset;
                w_next      = i_req_valid ? FETCH : IDLE;
            end
            FETCH: begin
                o_avm_chipselect = w_credit_ok;
                o_avm_address    = w_credit_ok ? r_base + ADDR_W'(r_word_idx) : '0;
                w_next           = (w_credit_ok && r_word_idx == WIDX_W'(WPR - 1)) ? DRAIN : FETCH;
            end
            DRAIN: w_next = (w_inflight == '0 && w_fifo_empty) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, word counter and fixed-latency return tracker
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_word_idx <= '0;
            r_sr_valid <= '0;
            r_sr_last  <= '0;
        end else begin
            r_state    <= w_next;
            r_sr_valid <= READ_LATENCY'({r_sr_valid, w_issue});
            r_sr_last  <= READ_LATENCY'({r_sr_last, w_issue && r_word_idx == WIDX_W'(WPR - 1)});
            if (r_state == IDLE && i_req_valid) begin
                r_base     <= row_base(i_req_sprite, i_req_row);
                r_word_idx <= '0;
            end else if (w_issue) begin
                r_word_idx <= r_word_idx + 1'b1;
            end
        end
    end

    sprite_word_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_sr_valid[READ_LATENCY-1]),
        .i_wdata ({r_sr_last[READ_LATENCY-1], i_avm_readdata}),
        .i_pop   (w_pop),
        .o_rdata ({w_head_last, w_head_data}),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// tb_sprite_row_fetcher: scoreboard bench for the sprite row fetcher at two latency/depth builds
module tb_sprite_row_fetcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rv0 = 1'b0, rdy0, cs0, ov0, ol0, busy0, ordy0, ordy_en0 = 1'b1, tog0 = 1'b0;
    logic [1:0]  spr0 = '0;
    logic [3:0]  row0 = '0;
    logic [7:0]  addr0;
    logic [31:0] rd0, od0;
    logic        rv1 = 1'b0, rdy1, cs1, ov1, ol1, busy1, ordy1 = 1'b1;
    logic [1:0]  spr1 = '0;
    logic [3:0]  row1 = '0;
    logic [7:0]  addr1;
    logic [31:0] rd1, od1, p1;

    assign ordy0 = tog0 ? cyc[0] : ordy_en0;

    sprite_row_fetcher dut0 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(rv0), .o_req_ready(rdy0),
        .i_req_sprite(spr0), .i_req_row(row0), .o_avm_address(addr0), .o_avm_chipselect(cs0),
        .i_avm_readdata(rd0), .o_out_valid(ov0), .i_out_ready(ordy0), .o_out_data(od0),
        .o_out_last(ol0), .o_busy(busy0)
    );

    sprite_row_fetcher #(.READ_LATENCY(2), .FIFO_DEPTH(3)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(rv1), .o_req_ready(rdy1),
        .i_req_sprite(spr1), .i_req_row(row1), .o_avm_address(addr1), .o_avm_chipselect(cs1),
        .i_avm_readdata(rd1), .o_out_valid(ov1), .i_out_ready(ordy1), .o_out_data(od1),
        .o_out_last(ol1), .o_busy(busy1)
    );

    function automatic logic [31:0] rom(input logic [7:0] a);
        return {a ^ 8'hA5, a, ~a, a + 8'h11};
    endfunction

    // ROM models: latency 1 and latency 2
    always @(posedge clk) rd0 <= rom(addr0);
    always @(posedge clk) begin
        p1  <= rom(addr1);
        rd1 <= p1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [32:0] qd0[$], qd1[$];
    logic [7:0]  qa0[$], qa1[$];
    int cs_n0, pop_n0, first_cs0, last_cs0, first_ov0, hs0;
    int cs_n1, pop_n1, first_ov1, hs1;

    // Scoreboard monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (cs0) begin
            if (cs_n0 == 0) first_cs0 = cyc;
            last_cs0 = cyc;
            cs_n0++;
            if (qa0.size() == 0) chk("addr0_extra", qa0.size(), 1);
            else chk("addr0", addr0, qa0.pop_front());
        end
        if (ov0 && first_ov0 < 0) first_ov0 = cyc;
        if (ov0 && ordy0) begin
            pop_n0++;
            if (qd0.size() == 0) chk("data0_extra", qd0.size(), 1);
            else chk("data0", {ol0, od0}, qd0.pop_front());
        end
        if (dut0.u_fifo.i_push && !dut0.w_pop && dut0.w_fifo_count == 3'd4) chk("ovf0", dut0.w_fifo_count, 3);
    end

    always @(negedge clk) begin
        if (cs1) begin
            cs_n1++;
            if (qa1.size() == 0) chk("addr1_extra", qa1.size(), 1);
            else chk("addr1", addr1, qa1.pop_front());
        end
        if (ov1 && first_ov1 < 0) first_ov1 = cyc;
        if (ov1 && ordy1) begin
            pop_n1++;
            if (qd1.size() == 0) chk("data1_extra", qd1.size(), 1);
            else chk("data1", {ol1, od1}, qd1.pop_front());
        end
        if (dut1.u_fifo.i_push && !dut1.w_pop && dut1.w_fifo_count == 2'd3) chk("ovf1", dut1.w_fifo_count, 2);
    end

    task automatic prep0();
        cs_n0 = 0; pop_n0 = 0; first_cs0 = -1; last_cs0 = -1; first_ov0 = -1;
    endtask

    task automatic prep1();
        cs_n1 = 0; pop_n1 = 0; first_ov1 = -1;
    endtask

    task automatic req0(input logic [1:0] s, input logic [3:0] r);
        int n = 0;
        logic [7:0] b;
        while (!rdy0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("req0_ready", rdy0, 1);
        b = 8'((s * 16 + r) * 4);
        for (int k = 0; k < 4; k++) begin
            qa0.push_back(b + 8'(k));
            qd0.push_back({k == 3, rom(b + 8'(k))});
        end
        spr0 = s; row0 = r; rv0 = 1'b1; hs0 = cyc;
        @(posedge clk); #1;
        rv0 = 1'b0;
    endtask

    task automatic req1(input logic [1:0] s, input logic [3:0] r);
        int n = 0;
        logic [7:0] b;
        while (!rdy1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("req1_ready", rdy1, 1);
        b = 8'((s * 16 + r) * 4);
        for (int k = 0; k < 4; k++) begin
            qa1.push_back(b + 8'(k));
            qd1.push_back({k == 3, rom(b + 8'(k))});
        end
        spr1 = s; row1 = r; rv1 = 1'b1; hs1 = cyc;
        @(posedge clk); #1;
        rv1 = 1'b0;
    endtask

    task automatic idle0(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy0 || qd0.size() != 0) && n < 200);
        chk(tag, n < 200, 1);
    endtask

    task automatic idle1(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy1 || qd1.size() != 0) && n < 200);
        chk(tag, n < 200, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prep0(); prep1();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy0, 0);
        chk("rst_cs", cs0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_busy", busy0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy0, 1);
        chk("post_rst_addr", addr0, 0);
        chk("post_rst_last", ol0, 0);
        chk("post_rst_ready1", rdy1, 1);

        // sprite 1 row 3, free-flowing output
        prep0();
        req0(2'd1, 4'd3);
        idle0("t1_idle");
        chk("t1_first_cs", first_cs0 - hs0, 1);
        chk("t1_last_cs", last_cs0 - hs0, 4);
        chk("t1_cs_n", cs_n0, 4);
        chk("t1_lat", first_ov0 - hs0, 3);
        chk("t1_pops", pop_n0, 4);

        // sprite 3 row 15, top of ROM
        prep0();
        req0(2'd3, 4'd15);
        idle0("t2_idle");
        chk("t2_busy", busy0, 0);
        chk("t2_ready", rdy0, 1);
        chk("t2_pops", pop_n0, 4);

        // consumer stalled for 10 cycles
        prep0();
        ordy_en0 = 1'b0;
        req0(2'd0, 4'd5);
        repeat (10) @(negedge clk);
        chk("t3_cs_n", cs_n0, 4);
        chk("t3_cs_low", cs0, 0);
        chk("t3_no_pop", pop_n0, 0);
        chk("t3_ov", ov0, 1);
        @(posedge clk); #1;
        ordy_en0 = 1'b1;
        idle0("t3_idle");
        chk("t3_pops", pop_n0, 4);

        // toggling ready across two requests
        prep0();
        tog0 = 1'b1;
        req0(2'd0, 4'd0);
        req0(2'd2, 4'd7);
        idle0("t4_idle");
        tog0 = 1'b0;
        chk("t4_pops", pop_n0, 8);

        // reset two cycles into FETCH
        prep0();
        req0(2'd1, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        qa0.delete(); qd0.delete();
        @(negedge clk);
        chk("t5_cs", cs0, 0);
        chk("t5_ov", ov0, 0);
        chk("t5_busy", busy0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        prep0();
        req0(2'd1, 4'd0);
        idle0("t5_idle");
        chk("t5_pops", pop_n0, 4);
        chk("t5_cs_n", cs_n0, 4);

        // latency-2, depth-3 build
        prep1();
        req1(2'd0, 4'd1);
        idle1("t6_idle");
        chk("t6_lat", first_ov1 - hs1, 4);
        chk("t6_pops", pop_n1, 4);
        prep1();
        ordy1 = 1'b0;
        req1(2'd2, 4'd5);
        repeat (10) @(negedge clk);
        chk("t6_cs_n", cs_n1, 3);
        chk("t6_cs_low", cs1, 0);
        @(posedge clk); #1;
        ordy1 = 1'b1;
        idle1("t6_bp_idle");
        chk("t6_bp_pops", pop_n1, 4);
        chk("t6_bp_cs_n", cs_n1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
